adder_tree_feeder: RTL



---
 rtl/adder_tree_pkg.sv | 15 +
 rtl/adder_tree_feeder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
//   Definitions shared by the adder tree blocks: default leaf operand width,
//   default lane count, the lane index width and the feeder state encoding.
package adder_tree_pkg;

  localparam int unsigned ADDER_WIDTH_DEFAULT = 13;
  localparam int unsigned LANES_DEFAULT       = 8;
  localparam int unsigned LANE_IDX_W          = $clog2(LANES_DEFAULT);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } feeder_state_t;

endpackage : adder_tree_pkg

// File: rtl/adder_tree_feeder.sv
// adder_tree_feeder
//   Serial-to-parallel operand loader for the adder tree leaves. Samples arrive
//   one per beat on a valid/ready stream and are packed into LANES lanes. Once
//   a group closes (lane LANES-1 written, or in_last), the whole lane vector is
//   presented with valid/ready. Unwritten lanes read zero.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     sample beat present
//   in_ready     loader accepts a beat (high for the whole FILL state)
//   in_data      unsigned sample, ADDER_WIDTH bits
//   in_last      final sample of a group (ignored without in_valid)
//   out_valid    lane vector valid (high for the whole HOLD state)
//   out_ready    consumer takes the vector
//   out_lanes    lane k at bits [k*ADDER_WIDTH +: ADDER_WIDTH]
//   out_count    number of real samples in the vector, 1..LANES
//   ref_sum      running sum of the group's samples; exists only when the
//                ADDER_TREE_FEEDER_REF_SUM_EN macro is defined
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int unsigned ADDER_WIDTH = ADDER_WIDTH_DEFAULT,
  parameter int unsigned LANES       = LANES_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ADDER_WIDTH-1:0]                 in_data,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LANES*ADDER_WIDTH-1:0]           out_lanes,
`ifdef ADDER_TREE_FEEDER_REF_SUM_EN
  output logic [$clog2(LANES):0]                 out_count,
  output logic [ADDER_WIDTH+$clog2(LANES)-1:0]   ref_sum
`else
  output logic [$clog2(LANES):0]                 out_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned CNT_W = IDX_W + 1;

  feeder_state_t                  state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [LANES*ADDER_WIDTH-1:0]   lanes_q, lanes_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           accept;
  logic                           group_end;
  logic                           release_vec;

  // Handshake flags are pure decodes of the registered state.
  assign in_ready    = (state_q == FILL);
  assign out_valid   = (state_q == HOLD);
  assign accept      = in_ready & in_valid;
  assign group_end   = accept & ((idx_q == IDX_W'(LANES - 1)) | in_last);
  assign release_vec = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    count_d = count_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (idx_q == IDX_W'(k)) begin
              lanes_d[k*ADDER_WIDTH +: ADDER_WIDTH] = in_data;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (group_end) begin
            count_d = CNT_W'({1'b0, idx_q}) + CNT_W'(1);
            idx_d   = '0;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Clearing on release is what zero-pads the next short group.
        if (out_ready) begin
          lanes_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      count_q <= count_d;
    end
  end

  assign out_lanes = lanes_q;
  assign out_count = count_q;

`ifdef ADDER_TREE_FEEDER_REF_SUM_EN
  localparam int unsigned SUM_W = ADDER_WIDTH + IDX_W;

  logic [SUM_W-1:0] ref_q, ref_d;

  always_comb begin
    ref_d = ref_q;
    if (release_vec) begin
      ref_d = '0;
    end else if (accept) begin
      ref_d = ref_q + SUM_W'(in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else begin
      ref_q <= ref_d;
    end
  end

  assign ref_sum = ref_q;
`else
  logic unused_release;
  assign unused_release = release_vec;
`endif

endmodule : adder_tree_feeder
